// File: rtl/srl_fifo_hs.sv
// srl_fifo_hs: shift-register FIFO with handshake, count and almost-full flag.
// Define SRL_FIFO_OUTREG_EN to add a registered output stage after the SRL.
module srl_fifo_hs #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  parameter  int AF_MARGIN  = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  almost_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] C_DEPTH = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_AF = ADDR_WIDTH'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH-1:0] C_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_srl [DEPTH];
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_full_n;
  logic                  r_af_n;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_srl_pop;
  logic [IW-1:0]         w_head_idx;
  logic [DATA_WIDTH-1:0] w_srl_head;

  assign w_push = if_write & if_write_ce & r_full_n;

  // Head sits at cnt-1; clamp to 0 when empty so the index stays in range.
  assign w_head_idx = (r_cnt == '0) ? '0 : IW'(r_cnt - C_ONE);
  assign w_srl_head = r_srl[w_head_idx];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_srl[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_srl[i] <= r_srl[i-1];
      end
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_srl_pop})
      2'b10:   w_cnt_nxt = r_cnt + C_ONE;
      2'b01:   w_cnt_nxt = r_cnt - C_ONE;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_full_n <= 1'b1;
      r_af_n   <= 1'b1;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_full_n <= (w_cnt_nxt != C_DEPTH);
      r_af_n   <= (w_cnt_nxt < C_AF);
    end
  end

  assign if_full_n     = r_full_n;
  assign almost_full_n = r_af_n;

`ifdef SRL_FIFO_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_vld;

  assign w_pop = if_read & if_read_ce & r_vld;
  // Refill the output flop whenever it is free or being drained.
  assign w_srl_pop = (~r_vld | w_pop) & (r_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
    end else if (w_srl_pop) begin
      r_dout <= w_srl_head;
      r_vld  <= 1'b1;
    end else if (w_pop) begin
      r_vld  <= 1'b0;
    end
  end

  assign if_dout           = r_dout;
  assign if_empty_n        = r_vld;
  assign if_num_data_valid = {1'b0, r_cnt} + {{ADDR_WIDTH{1'b0}}, r_vld};
  assign if_fifo_cap       = (ADDR_WIDTH+1)'(DEPTH + 1);
`else
  logic r_empty_n;

  assign w_pop     = if_read & if_read_ce & r_empty_n;
  assign w_srl_pop = w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_empty_n <= 1'b0;
    end else begin
      r_empty_n <= (w_cnt_nxt != '0);
    end
  end

  assign if_dout           = w_srl_head;
  assign if_empty_n        = r_empty_n;
  assign if_num_data_valid = {1'b0, r_cnt};
  assign if_fifo_cap       = (ADDR_WIDTH+1)'(DEPTH);
`endif

endmodule

// File: tb/tb_srl_fifo_hs.sv
// tb_srl_fifo_hs: directed vector bench for srl_fifo_hs (DEPTH=16, AF_MARGIN=2).
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_srl_fifo_hs;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we = 1'b0, wr = 1'b0, rce = 1'b0, rd = 1'b0;
  logic [DW-1:0] din = '0;
  logic          full_n, af_n, empty_n;
  logic [DW-1:0] dout;
  logic [AW:0]   num, cap;

  int n_vec = 0;
  int n_err = 0;

  srl_fifo_hs #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(2)) dut (
    .clk(clk), .reset(reset),
    .if_write_ce(we), .if_write(wr), .if_din(din),
    .if_full_n(full_n), .almost_full_n(af_n),
    .if_read_ce(rce), .if_read(rd), .if_dout(dout),
    .if_empty_n(empty_n), .if_num_data_valid(num),
    .if_fifo_cap(cap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we, wr, rce, rd;
    logic [DW-1:0] din;
    logic          full_n, af_n, empty_n;
    int            cnt;
    logic          chk_dout;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic w, input logic r, input logic [DW-1:0] d);
    we = w; wr = w; rce = r; rd = r; din = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic add(input logic w_ce, input logic w, input logic [DW-1:0] d,
                     input logic r_ce, input logic r,
                     input logic f, input logic a, input logic e,
                     input int c, input logic cd, input logic [DW-1:0] o);
    vec_t v;
    v.we = w_ce; v.wr = w; v.din = d; v.rce = r_ce; v.rd = r;
    v.full_n = f; v.af_n = a; v.empty_n = e; v.cnt = c;
    v.chk_dout = cd; v.dout = o;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    drv(1'b0, 1'b0, '0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_empty_n", 64'(empty_n), 64'd0);
    chk("rst_full_n", 64'(full_n), 64'd1);
    chk("rst_af_n", 64'(af_n), 64'd1);
    chk("rst_num", 64'(num), 64'd0);

`ifdef SRL_FIFO_OUTREG_EN
    chk("cap", 64'(cap), 64'd17);
    drv(1'b1, 1'b0, 32'hA5);
    tick();
    drv(1'b0, 1'b0, '0);
    chk("or_lat1_empty_n", 64'(empty_n), 64'd0);
    chk("or_lat1_num", 64'(num), 64'd1);
    tick();
    chk("or_lat2_empty_n", 64'(empty_n), 64'd1);
    chk("or_dout", 64'(dout), 64'hA5);
    chk("or_num", 64'(num), 64'd1);
    chk("or_cap", 64'(cap), 64'd17);
    drv(1'b0, 1'b1, '0);
    tick();
    drv(1'b0, 1'b0, '0);
    chk("or_pop_empty_n", 64'(empty_n), 64'd0);
    chk("or_pop_num", 64'(num), 64'd0);
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 1'b0, DW'(32'h10 + k));
      tick();
    end
    drv(1'b0, 1'b0, '0);
    tick();
    chk("or_burst_num", 64'(num), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk("or_burst_dout", 64'(dout), 64'(32'h10 + k));
      drv(1'b0, 1'b1, '0);
      tick();
    end
    drv(1'b0, 1'b0, '0);
    chk("or_burst_empty", 64'(empty_n), 64'd0);
`else
    chk("cap", 64'(cap), 64'd16);

    // Vector table: write ce gating, fill, overflow, read ce gating, drain.
    add(1'b0, 1'b1, 32'd99, 1'b0, 1'b0, 1, 1, 0, 0, 0, '0);
    for (int k = 0; k < 16; k++)
      add(1'b1, 1'b1, DW'(k), 1'b0, 1'b0,
          (k + 1 != 16), (k + 1 < 14), 1, k + 1, 1, '0);
    add(1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 0, 0, 1, 16, 1, '0);
    add(1'b0, 1'b0, '0, 1'b0, 1'b1, 0, 0, 1, 16, 1, '0);
    for (int j = 0; j < 16; j++)
      add(1'b0, 1'b0, '0, 1'b1, 1'b1,
          1, (15 - j < 14), (j != 15), 15 - j, (j != 15), DW'(j + 1));
    add(1'b0, 1'b0, '0, 1'b1, 1'b1, 1, 1, 0, 0, 0, '0);

    foreach (tbl[i]) begin
      we = tbl[i].we; wr = tbl[i].wr; din = tbl[i].din;
      rce = tbl[i].rce; rd = tbl[i].rd;
      tick();
      chk($sformatf("v%0d_full_n", i), 64'(full_n), 64'(tbl[i].full_n));
      chk($sformatf("v%0d_af_n", i), 64'(af_n), 64'(tbl[i].af_n));
      chk($sformatf("v%0d_empty_n", i), 64'(empty_n), 64'(tbl[i].empty_n));
      chk($sformatf("v%0d_num", i), 64'(num), 64'(tbl[i].cnt));
      if (tbl[i].chk_dout)
        chk($sformatf("v%0d_dout", i), 64'(dout), 64'(tbl[i].dout));
    end
    drv(1'b0, 1'b0, '0);

    // Steady state at 8 entries with simultaneous push and pop.
    for (int k = 0; k < 8; k++) begin
      drv(1'b1, 1'b0, DW'(100 + k));
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      chk("ss_dout", 64'(dout), 64'(100 + i));
      chk("ss_num", 64'(num), 64'd8);
      drv(1'b1, 1'b1, DW'(108 + i));
      tick();
    end
    drv(1'b0, 1'b0, '0);
    for (int k = 0; k < 8; k++) begin
      chk("ss_drain", 64'(dout), 64'(200 + k));
      drv(1'b0, 1'b1, '0);
      tick();
    end
    drv(1'b0, 1'b0, '0);
    chk("ss_empty", 64'(empty_n), 64'd0);

    // Full FIFO: push+pop performs only the pop.
    for (int k = 0; k < 16; k++) begin
      drv(1'b1, 1'b0, DW'(32'h300 + k));
      tick();
    end
    chk("full_flag", 64'(full_n), 64'd0);
    drv(1'b1, 1'b1, 32'hDEAD);
    tick();
    drv(1'b0, 1'b0, '0);
    chk("full_pp_num", 64'(num), 64'd15);
    chk("full_pp_full_n", 64'(full_n), 64'd1);
    for (int k = 0; k < 15; k++) begin
      chk("full_drain", 64'(dout), 64'(32'h301 + k));
      drv(1'b0, 1'b1, '0);
      tick();
    end
    drv(1'b0, 1'b0, '0);
    chk("full_drain_empty", 64'(empty_n), 64'd0);
    chk("full_drain_num", 64'(num), 64'd0);

    // Asynchronous reset in the middle of a write burst.
    for (int k = 0; k < 5; k++) begin
      drv(1'b1, 1'b0, DW'(32'h400 + k));
      tick();
    end
    chk("pre_rst_num", 64'(num), 64'd5);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_num", 64'(num), 64'd0);
    tick();
    chk("mid_rst_empty_n", 64'(empty_n), 64'd0);
    chk("mid_rst_full_n", 64'(full_n), 64'd1);
    chk("mid_rst_af_n", 64'(af_n), 64'd1);
    chk("mid_rst_num", 64'(num), 64'd0);
    reset = 1'b0;
    drv(1'b1, 1'b0, 32'h55);
    tick();
    drv(1'b0, 1'b0, '0);
    chk("post_rst_num", 64'(num), 64'd1);
    chk("post_rst_empty_n", 64'(empty_n), 64'd1);
    chk("post_rst_dout", 64'(dout), 64'h55);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
